// File: rtl/gpu_bus_arbiter.sv
// gpu_bus_arbiter: registered one-hot arbiter for the shared main bus with drain and turnaround gaps
module gpu_bus_arbiter #(
    parameter int TURN_CYCLES  = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_breq,
    input  logic       gpu_breq,
    input  logic [1:0] blit_breq,
    input  logic       dma_breq,
    input  logic       lock,
    input  logic       mreq_in,
    output logic       cpu_bg,
    output logic       gpu_back,
    output logic       blit_back,
    output logic       dma_back,
    output logic [2:0] owner,
    output logic       bus_idle
);
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN, TURN} state_t;
    localparam logic [2:0] OWN_NONE = 3'd0;
    localparam logic [2:0] OWN_CPU  = 3'd1;
    localparam logic [2:0] OWN_GPU  = 3'd2;
    localparam logic [2:0] OWN_BLIT = 3'd3;
    localparam logic [2:0] OWN_DMA  = 3'd4;
    state_t     state, state_nx;
    logic [2:0] owner_nx, turn_cnt, turn_nx, winner;
    logic [3:0] starve_cnt, starve_nx, grant_nx;
    logic       promoted, hold, any_req;
    assign promoted = starve_cnt == 4'(STARVE_LIMIT);
    assign any_req  = cpu_breq | gpu_breq | (|blit_breq) | dma_breq;
    assign winner   = dma_breq                          ? OWN_DMA  :
                      (blit_breq[1] | (blit_breq[0] & promoted)) ? OWN_BLIT :
                      gpu_breq                          ? OWN_GPU  :
                      blit_breq[0]                      ? OWN_BLIT :
                      cpu_breq                          ? OWN_CPU  : OWN_NONE;
    assign hold     = owner == OWN_CPU  ? cpu_breq :
                      owner == OWN_GPU  ? (gpu_breq | lock) :
                      owner == OWN_BLIT ? (|blit_breq) :
                      owner == OWN_DMA  ? dma_breq : 1'b0;
    // next state, owner, turnaround count and grant vector {cpu, gpu, blit, dma}
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        turn_nx  = turn_cnt;
        grant_nx = 4'b0000;
        case (state)
            IDLE: if (any_req) begin
                state_nx = GRANT;
                owner_nx = winner;
                grant_nx = {winner == OWN_CPU, winner == OWN_GPU, winner == OWN_BLIT, winner == OWN_DMA};
            end
            GRANT: if (hold) grant_nx = {cpu_bg, gpu_back, blit_back, dma_back};
                   else state_nx = DRAIN;
            DRAIN: if (!mreq_in) begin
                state_nx = TURN;
                turn_nx  = 3'(TURN_CYCLES - 1);
            end
            TURN: if (turn_cnt == 3'd0) begin
                state_nx = IDLE;
                owner_nx = OWN_NONE;
            end else turn_nx = turn_cnt - 3'd1;
            default: state_nx = IDLE;
        endcase
        starve_nx = (blit_breq == 2'b00 || (grant_nx[1] && !blit_back)) ? 4'd0 :
                    (blit_breq[0] && !blit_back && !promoted)          ? starve_cnt + 4'd1 : starve_cnt;
    end
    // state, counters and registered outputs; reset drops every grant at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            turn_cnt   <= 3'd0;
            starve_cnt <= 4'd0;
            {cpu_bg, gpu_back, blit_back, dma_back} <= 4'b0000;
            bus_idle   <= 1'b1;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            turn_cnt   <= turn_nx;
            starve_cnt <= starve_nx;
            {cpu_bg, gpu_back, blit_back, dma_back} <= grant_nx;
            bus_idle   <= state_nx == IDLE;
        end
    end
endmodule

// File: tb/tb_gpu_bus_arbiter.sv
// tb_gpu_bus_arbiter: directed checks of grant priority, lock, drain, starvation and async reset
module tb_gpu_bus_arbiter;
    logic       clk = 1'b0, reset_n;
    logic       cpu_breq, gpu_breq, dma_breq, lock, mreq_in;
    logic [1:0] blit_breq;
    logic       cpu_bg, gpu_back, blit_back, dma_back, bus_idle;
    logic [2:0] owner;
    logic [3:0] g;
    int         n_vec = 0, n_bad = 0;

    gpu_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n), .cpu_breq(cpu_breq), .gpu_breq(gpu_breq),
        .blit_breq(blit_breq), .dma_breq(dma_breq), .lock(lock), .mreq_in(mreq_in),
        .cpu_bg(cpu_bg), .gpu_back(gpu_back), .blit_back(blit_back), .dma_back(dma_back),
        .owner(owner), .bus_idle(bus_idle)
    );

    assign g = {cpu_bg, gpu_back, blit_back, dma_back};

    // free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // inputs change and outputs are sampled on falling edges
    initial begin
        reset_n = 1'b0; cpu_breq = 0; gpu_breq = 0; blit_breq = 2'b00;
        dma_breq = 0; lock = 0; mreq_in = 0;
        repeat (2) @(negedge clk);
        chk("rst_grants", 32'(g), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_idle", 32'(bus_idle), 1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 32'(bus_idle), 1);
        // basic grant and release with a simultaneous new request
        gpu_breq = 1;
        @(negedge clk);
        chk("basic_grant", 32'(g), 4'b0100);
        chk("basic_owner", 32'(owner), 2);
        chk("basic_busy", 32'(bus_idle), 0);
        repeat (6) @(negedge clk);
        chk("basic_hold", 32'(g), 4'b0100);
        gpu_breq = 0; cpu_breq = 1;
        @(negedge clk);
        chk("drain_grants", 32'(g), 0);
        chk("drain_owner", 32'(owner), 2);
        @(negedge clk);
        chk("turn_grants", 32'(g), 0);
        chk("turn_owner", 32'(owner), 2);
        @(negedge clk);
        chk("gap_grants", 32'(g), 0);
        chk("gap_owner", 32'(owner), 0);
        chk("gap_idle", 32'(bus_idle), 1);
        @(negedge clk);
        chk("cpu_after_gap", 32'(g), 4'b1000);
        chk("cpu_owner", 32'(owner), 1);
        cpu_breq = 0;
        repeat (3) @(negedge clk);
        chk("cpu_released", 32'(bus_idle), 1);
        // priority among simultaneous requests
        dma_breq = 1; gpu_breq = 1; cpu_breq = 1;
        @(negedge clk);
        chk("prio_dma", 32'(g), 4'b0001);
        chk("prio_dma_owner", 32'(owner), 4);
        dma_breq = 0;
        repeat (3) @(negedge clk);
        chk("prio_gap", 32'(g), 0);
        @(negedge clk);
        chk("prio_gpu", 32'(g), 4'b0100);
        repeat (2) @(negedge clk);
        chk("prio_gpu_hold", 32'(g), 4'b0100);
        gpu_breq = 0;
        repeat (3) @(negedge clk);
        chk("prio_gap2", 32'(g), 0);
        @(negedge clk);
        chk("prio_cpu", 32'(g), 4'b1000);
        cpu_breq = 0;
        repeat (3) @(negedge clk);
        // lock keeps the gpu, ignored for the blitter
        gpu_breq = 1;
        @(negedge clk);
        chk("lock_gpu", 32'(g), 4'b0100);
        lock = 1; gpu_breq = 0;
        repeat (5) @(negedge clk);
        chk("lock_hold", 32'(g), 4'b0100);
        lock = 0;
        @(negedge clk);
        chk("lock_release", 32'(g), 0);
        repeat (2) @(negedge clk);
        blit_breq = 2'b10; lock = 1;
        @(negedge clk);
        chk("blit_grant", 32'(g), 4'b0010);
        chk("blit_owner", 32'(owner), 3);
        blit_breq = 2'b00;
        @(negedge clk);
        chk("lock_ignored", 32'(g), 0);
        lock = 0;
        repeat (2) @(negedge clk);
        chk("lock_idle", 32'(bus_idle), 1);
        // drain stretched by mreq_in, no preemption
        blit_breq = 2'b10;
        @(negedge clk);
        chk("drain_blit", 32'(g), 4'b0010);
        cpu_breq = 1; mreq_in = 1;
        @(negedge clk);
        chk("no_preempt", 32'(g), 4'b0010);
        blit_breq = 2'b00;
        @(negedge clk);
        chk("drain_start", 32'(g), 0);
        repeat (3) @(negedge clk);
        chk("drain_stretch_owner", 32'(owner), 3);
        chk("drain_stretch_busy", 32'(bus_idle), 0);
        chk("drain_stretch_grants", 32'(g), 0);
        mreq_in = 0;
        @(negedge clk);
        chk("drain_turn_owner", 32'(owner), 3);
        @(negedge clk);
        chk("drain_idle", 32'(bus_idle), 1);
        @(negedge clk);
        chk("drain_cpu", 32'(g), 4'b1000);
        cpu_breq = 0;
        repeat (3) @(negedge clk);
        // starvation promotion of blit_breq[0]
        chk("starve_start", 32'(dut.starve_cnt), 0);
        gpu_breq = 1; blit_breq = 2'b01;
        @(negedge clk);
        chk("gpu_beats_blit0", 32'(g), 4'b0100);
        repeat (13) @(negedge clk);
        chk("starve_14", 32'(dut.starve_cnt), 14);
        @(negedge clk);
        chk("starve_15", 32'(dut.starve_cnt), 15);
        repeat (3) @(negedge clk);
        chk("starve_sat", 32'(dut.starve_cnt), 15);
        gpu_breq = 0;
        @(negedge clk);
        gpu_breq = 1;
        repeat (2) @(negedge clk);
        chk("starve_gap", 32'(g), 0);
        @(negedge clk);
        chk("starve_win", 32'(g), 4'b0010);
        chk("starve_clear", 32'(dut.starve_cnt), 0);
        blit_breq = 2'b00;
        repeat (4) @(negedge clk);
        chk("gpu_after_blit", 32'(g), 4'b0100);
        gpu_breq = 0;
        repeat (3) @(negedge clk);
        // asynchronous reset mid-grant
        dma_breq = 1;
        @(negedge clk);
        chk("rst_pre_dma", 32'(g), 4'b0001);
        #2 reset_n = 1'b0;
        #2;
        chk("async_grants", 32'(g), 0);
        chk("async_owner", 32'(owner), 0);
        chk("async_idle", 32'(bus_idle), 1);
        dma_breq = 0; reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(g), 0);
        dma_breq = 1;
        @(negedge clk);
        chk("post_rst_grant", 32'(g), 4'b0001);
        chk("post_rst_owner", 32'(owner), 4);
        dma_breq = 0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
